// File: rtl/tcdm_mem_responder.sv
// Single-port TCDM bank model: byte-enabled writes, fixed-latency reads, a response FIFO that
// absorbs r_ready backpressure, and a credit limit on outstanding reads that throttles gnt.
module tcdm_mem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    gnt_stall_i,
    input  logic                    req,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    wen,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic                    gnt,
    output logic                    r_valid,
    output logic [DATA_WIDTH-1:0]   r_data,
    input  logic                    r_ready
);
    localparam int unsigned NBYTES   = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = $clog2(NBYTES);
    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PTR_W    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];

    logic [IDX_W-1:0]      idx;
    logic                  accept_wr, accept_rd;
    logic                  push, pop, fifo_full;
    logic [DATA_WIDTH-1:0] push_data;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic                  unused_addr;

    // Byte-offset and upper address bits are deliberately dropped, so addresses alias.
    assign idx         = addr[ADDR_LSB +: IDX_W];
    assign unused_addr = ^addr;

    assign gnt       = req & ~rst_i & ~gnt_stall_i & (wen | (outstanding_q < CNT_W'(RESP_DEPTH)));
    assign accept_wr = req & gnt & wen;
    assign accept_rd = req & gnt & ~wen;

    assign fifo_full = (fifo_cnt_q == CNT_W'(RESP_DEPTH));
    assign r_valid   = (fifo_cnt_q != '0);
    assign pop       = r_valid & r_ready;
    assign r_data    = r_valid ? fifo_q[rd_ptr_q] : last_q;

    always_ff @(posedge clk_i) begin
        if (accept_wr) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= data[8*i +: 8];
                end
            end
        end
    end

    // Stage 0 captures the array at the edge ending the accept cycle; the last stage feeds the FIFO.
    generate
        if (LATENCY > 1) begin : g_pipe
            logic [LATENCY-2:0]    pv_q, pv_d;
            logic [DATA_WIDTH-1:0] pd_q [LATENCY-1];
            logic [DATA_WIDTH-1:0] pd_d [LATENCY-1];

            always_comb begin
                pv_d[0] = accept_rd;
                pd_d[0] = mem_q[idx];
                for (int k = 1; k < LATENCY - 1; k++) begin
                    pv_d[k] = pv_q[k-1];
                    pd_d[k] = pd_q[k-1];
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    pv_q <= '0;
                end else begin
                    pv_q <= pv_d;
                end
                pd_q <= pd_d;
            end

            assign push      = pv_q[LATENCY-2];
            assign push_data = pd_q[LATENCY-2];
        end else begin : g_nopipe
            assign push      = accept_rd;
            assign push_data = mem_q[idx];
        end
    endgenerate

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        last_d        = last_q;
        outstanding_d = outstanding_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            last_d   = fifo_q[rd_ptr_q];
        end

        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end

        // Counts reads from accept to handshake, covering both pipeline and FIFO occupancy.
        if (accept_rd && !pop) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (!accept_rd && pop) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            last_q        <= '0;
            outstanding_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            last_q        <= last_d;
            outstanding_q <= outstanding_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && fifo_full));

endmodule

// File: tb/tb_tcdm_mem_responder.sv
// Directed bench for tcdm_mem_responder: hand-computed expectations checked with immediate asserts.
module tb_tcdm_mem_responder;
    logic        clk = 1'b0;
    logic        rst, stall, req, wen, gnt, r_valid, r_ready;
    logic [31:0] addr, data, r_data;
    logic [3:0]  be;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    tcdm_mem_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH     (1024),
        .LATENCY   (2),
        .RESP_DEPTH(4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .gnt_stall_i(stall),
        .req        (req),
        .addr       (addr),
        .wen        (wen),
        .data       (data),
        .be         (be),
        .gnt        (gnt),
        .r_valid    (r_valid),
        .r_data     (r_data),
        .r_ready    (r_ready)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        req  = 1'b0;
        wen  = 1'b0;
        addr = '0;
        data = '0;
        be   = '0;
    endtask

    task automatic rd(input logic [31:0] a);
        req  = 1'b1;
        wen  = 1'b0;
        addr = a;
        data = '0;
        be   = 4'hF;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req  = 1'b1;
        wen  = 1'b1;
        addr = a;
        data = d;
        be   = b;
    endtask

    initial begin
        rst     = 1'b1;
        stall   = 1'b0;
        r_ready = 1'b1;
        idle();
        cyc();
        cyc();

        // Reset state, and gnt held low while reset is high.
        rd(32'h10);
        settle();
        check1("gnt_in_reset", gnt, 1'b0);
        check1("rvalid_reset", r_valid, 1'b0);
        check32("rdata_reset", r_data, 32'h0);
        rst = 1'b0;
        idle();

        // Full write then read, latency 2.
        cyc(); wr(32'h10, 32'hDEADBEEF, 4'hF); settle();
        check1("t1_wr_gnt", gnt, 1'b1);
        cyc(); rd(32'h10); settle();
        check1("t1_rd_gnt", gnt, 1'b1);
        cyc(); idle(); settle();
        check1("t1_rvalid_c1", r_valid, 1'b0);
        cyc(); settle();
        check1("t1_rvalid_c2", r_valid, 1'b1);
        check32("t1_rdata", r_data, 32'hDEADBEEF);
        cyc(); settle();
        check1("t1_rvalid_after", r_valid, 1'b0);
        check32("t1_rdata_hold", r_data, 32'hDEADBEEF);

        // Partial byte-enable write.
        cyc(); wr(32'h10, 32'h11223344, 4'b0101); settle();
        check1("t2_wr_gnt", gnt, 1'b1);
        cyc(); rd(32'h10);
        cyc(); idle();
        cyc(); settle();
        check1("t2_rvalid", r_valid, 1'b1);
        check32("t2_rdata", r_data, 32'hDE22BE44);

        // Aliasing modulo DEPTH words.
        cyc(); wr(32'h1010, 32'hCAFEF00D, 4'hF);
        cyc(); rd(32'h10); settle();
        check1("t4_rd_gnt", gnt, 1'b1);
        cyc(); idle();
        cyc(); settle();
        check1("t4_rvalid", r_valid, 1'b1);
        check32("t4_rdata", r_data, 32'hCAFEF00D);

        // Credit limit under backpressure.
        for (int i = 0; i < 6; i++) begin
            cyc(); wr(32'(4 * i), 32'(32'hA000_0000 + i), 4'hF);
        end
        cyc(); idle(); r_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic exp_g;
            exp_g = (i < 4);
            cyc(); rd(32'(4 * i)); settle();
            check1($sformatf("t3_gnt_rd%0d", i), gnt, exp_g);
        end
        check1("t3_rvalid_held", r_valid, 1'b1);
        check32("t3_rdata_held", r_data, 32'hA000_0000);
        cyc(); rd(32'h10); r_ready = 1'b1; settle();
        check1("t3_gnt_same_cycle", gnt, 1'b0);
        check32("t3_resp0", r_data, 32'hA000_0000);
        cyc(); settle();
        check1("t3_gnt_next_cycle", gnt, 1'b1);
        check32("t3_resp1", r_data, 32'hA000_0001);
        cyc(); idle(); settle();
        check32("t3_resp2", r_data, 32'hA000_0002);
        cyc(); settle();
        check32("t3_resp3", r_data, 32'hA000_0003);
        cyc(); settle();
        check1("t3_rvalid4", r_valid, 1'b1);
        check32("t3_resp4", r_data, 32'hA000_0004);
        cyc(); settle();
        check1("t3_drained", r_valid, 1'b0);

        // Reset with two reads in flight.
        r_ready = 1'b0;
        cyc(); rd(32'h4); settle();
        check1("t5_rd1_gnt", gnt, 1'b1);
        cyc(); rd(32'h8); settle();
        check1("t5_rd2_gnt", gnt, 1'b1);
        cyc(); idle(); rst = 1'b1;
        cyc(); rst = 1'b0; r_ready = 1'b1; settle();
        check1("t5_rvalid_post_rst", r_valid, 1'b0);
        check32("t5_rdata_post_rst", r_data, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(); settle();
            check1($sformatf("t5_no_stale%0d", i), r_valid, 1'b0);
        end
        r_ready = 1'b0;
        cyc(); rd(32'h10); settle();
        check1("t5_gnt0", gnt, 1'b1);
        cyc(); rd(32'h0); settle();
        check1("t5_gnt1", gnt, 1'b1);
        cyc(); rd(32'h4); settle();
        check1("t5_gnt2", gnt, 1'b1);
        cyc(); rd(32'h8); settle();
        check1("t5_gnt3", gnt, 1'b1);
        cyc(); rd(32'hC); settle();
        check1("t5_gnt4_blocked", gnt, 1'b0);
        check1("t5_rvalid", r_valid, 1'b1);
        check32("t5_resp0", r_data, 32'hA000_0004);
        idle(); r_ready = 1'b1;
        cyc(); settle();
        check32("t5_resp1", r_data, 32'hA000_0000);
        cyc(); settle();
        check32("t5_resp2", r_data, 32'hA000_0001);
        cyc(); settle();
        check32("t5_resp3", r_data, 32'hA000_0002);
        cyc(); settle();
        check1("t5_drained", r_valid, 1'b0);

        // Stall hook blocks gnt but not the response path.
        cyc(); rd(32'h8); settle();
        check1("t6_pre_gnt", gnt, 1'b1);
        cyc(); stall = 1'b1; rd(32'hC); settle();
        check1("t6_stall_gnt0", gnt, 1'b0);
        check1("t6_stall_rv0", r_valid, 1'b0);
        cyc(); settle();
        check1("t6_stall_gnt1", gnt, 1'b0);
        check1("t6_drain_rv", r_valid, 1'b1);
        check32("t6_drain_data", r_data, 32'hA000_0002);
        cyc(); settle();
        check1("t6_stall_gnt2", gnt, 1'b0);
        check1("t6_stall_rv2", r_valid, 1'b0);
        cyc(); stall = 1'b0; settle();
        check1("t6_unstall_gnt", gnt, 1'b1);
        check1("t6_unstall_rv", r_valid, 1'b0);
        cyc(); idle(); settle();
        check1("t6_rv_c1", r_valid, 1'b0);
        cyc(); settle();
        check1("t6_rv_c2", r_valid, 1'b1);
        check32("t6_rdata", r_data, 32'hA000_0003);
        cyc(); settle();
        check1("t6_rv_end", r_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
